// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 synchronous FIFO transmit/receive paths.
package ft245_pkg;

  localparam int FT_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_TURN = 3'd2,
    ST_SEND = 3'd3,
    ST_REL  = 3'd4
  } ft_state_e;

  // Bits needed for a counter that must be able to hold the value max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ft245_tx_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy output; head_o is valid whenever empty_o is low.
module ft245_tx_fifo
  import ft245_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = FT_BYTE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic          push_ok, pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Full blocks a push even when a pop happens on the same edge.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      level_q <= level_q + 1'b1;
      else if (pop_ok && !push_ok) level_q <= level_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ft245_tx.sv
// FT245 sync-FIFO transmit path: buffers controller bytes and bursts them onto ft_bus under TXE#.
// Optional SIWU# send-immediate pulse after an idle period is enabled with FT245_TX_SIWU_EN.
module ft245_tx
  import ft245_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 64,
  parameter int SIWU_IDLE  = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [FT_BYTE_W-1:0]          s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          bus_req,
  input  logic                          bus_gnt,
  input  logic                          ft_txe_n,
  output logic                          ft_wr_n,
  output logic [FT_BYTE_W-1:0]          ft_dout,
  output logic                          ft_dout_oe,
  output logic                          ft_siwu_n,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx_busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = cnt_w(MAX_BURST);

  ft_state_e state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;

  logic [FT_BYTE_W-1:0] head;
  logic fifo_full, fifo_empty;
  logic push, wr_en;
  logic [LW-1:0] level_after;

  assign s_ready = ~rst & ~fifo_full;
  assign push    = s_valid & s_ready;
  // Write strobe is combinational from TXE# and grant so it drops in the same cycle either goes away.
  assign wr_en   = (state_q == ST_SEND) & ~fifo_empty & ~ft_txe_n & bus_gnt;
  assign tx_busy = (state_q != ST_IDLE) | ~fifo_empty;

  ft245_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FT_BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (s_data),
    .pop_i   (wr_en),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign level_after = fifo_level + LW'(push) - LW'(wr_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q + BW'(wr_en);
    unique case (state_q)
      ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
      ST_REQ:  if (bus_gnt) state_d = ST_TURN;
      ST_TURN: state_d = ST_SEND;
      ST_SEND: begin
        if (level_after == '0 || burst_d == BW'(MAX_BURST) || !bus_gnt)
          state_d = ST_REL;
      end
      ST_REL: begin
        state_d = ST_IDLE;
        burst_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req    = 1'b0;
    ft_dout_oe = 1'b0;
    ft_wr_n    = ~wr_en;
    ft_dout    = fifo_empty ? '0 : head;
    unique case (state_q)
      ST_REQ:  bus_req = 1'b1;
      ST_TURN: begin
        bus_req    = 1'b1;
        ft_dout_oe = 1'b1;
      end
      ST_SEND: begin
        bus_req    = 1'b1;
        ft_dout_oe = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef FT245_TX_SIWU_EN
  localparam int IW = cnt_w(SIWU_IDLE);

  logic [IW-1:0] idle_q, idle_d;
  logic          siwu_q, siwu_d;

  // Counter parks at SIWU_IDLE after reset so no pulse fires until something has been written.
  always_comb begin
    idle_d = idle_q;
    if (wr_en)
      idle_d = '0;
    else if (!tx_busy && idle_q != IW'(SIWU_IDLE))
      idle_d = idle_q + 1'b1;
    siwu_d = ~((idle_d == IW'(SIWU_IDLE)) & (idle_q != IW'(SIWU_IDLE)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= IW'(SIWU_IDLE);
      siwu_q <= 1'b1;
    end else begin
      idle_q <= idle_d;
      siwu_q <= siwu_d;
    end
  end

  assign ft_siwu_n = siwu_q;
`else
  assign ft_siwu_n = 1'b1;
`endif

endmodule

// File: tb/tb_ft245_tx.sv
// Randomized bench for ft245_tx against a queue-based model of the byte stream and bus rules.
module tb_ft245_tx;

  localparam int DEPTH = 16;
  localparam int MAXB  = 4;
  localparam int SIWU  = 8;

  logic       clk, rst;
  logic [7:0] s_data;
  logic       s_valid, s_ready;
  logic       bus_req, bus_gnt;
  logic       ft_txe_n, ft_wr_n;
  logic [7:0] ft_dout;
  logic       ft_dout_oe, ft_siwu_n, tx_busy;
  logic [4:0] fifo_level;

  logic arb_en, gnt_block, gnt_q;

  int n_vec = 0;
  int n_miss = 0;
  int n_wr = 0;
  int n_pulse = 0;
  int burst_len = 0;
  logic prev_req = 1'b0;
  int idle_cnt = SIWU;
  logic siwu_pend = 1'b0;
  logic [7:0] exp_q [$];
  int bursts [$];

  ft245_tx #(
    .FIFO_DEPTH (DEPTH),
    .MAX_BURST  (MAXB),
    .SIWU_IDLE  (SIWU)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .ft_txe_n   (ft_txe_n),
    .ft_wr_n    (ft_wr_n),
    .ft_dout    (ft_dout),
    .ft_dout_oe (ft_dout_oe),
    .ft_siwu_n  (ft_siwu_n),
    .fifo_level (fifo_level),
    .tx_busy    (tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Arbiter: grant follows request one cycle later, gated by test controls.
  always @(posedge clk) gnt_q <= bus_req;
  assign bus_gnt = gnt_q & arb_en & ~gnt_block;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model, evaluated mid-cycle for the edge that follows.
  always @(negedge clk) begin
    int lvl;
    logic wrote;
    if (rst) begin
      exp_q.delete();
      burst_len = 0;
      prev_req  = 1'b0;
      idle_cnt  = SIWU;
      siwu_pend = 1'b0;
    end else begin
      lvl   = exp_q.size();
      wrote = 1'b0;
      chk("level", 32'(fifo_level), 32'(lvl));
      chk("s_ready", 32'(s_ready), 32'(lvl < DEPTH));
      if (lvl != 0) chk("busy", 32'(tx_busy), 1);
      if (ft_txe_n || !bus_gnt) chk("wr_hold", 32'(ft_wr_n), 1);
      chk("siwu", 32'(ft_siwu_n), 32'(!siwu_pend));
      if (!ft_siwu_n) n_pulse++;
      if (!ft_wr_n) begin
        chk("wr_oe", 32'(ft_dout_oe), 1);
        if (lvl == 0) chk("wr_underflow", 32'(ft_wr_n), 1);
        else chk("dout", 32'(ft_dout), 32'(exp_q.pop_front()));
        n_wr++;
        burst_len++;
        wrote = 1'b1;
      end
      if (s_valid && lvl < DEPTH) exp_q.push_back(s_data);
      if (prev_req && !bus_req) begin
        chk("burst_max", 32'(burst_len <= MAXB), 1);
        bursts.push_back(burst_len);
        burst_len = 0;
      end
      prev_req = bus_req;
      siwu_pend = 1'b0;
`ifdef FT245_TX_SIWU_EN
      if (wrote) idle_cnt = 0;
      else if (!tx_busy && idle_cnt < SIWU) begin
        idle_cnt++;
        if (idle_cnt == SIWU) siwu_pend = 1'b1;
      end
`else
      if (wrote) idle_cnt = 0;
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    s_data  = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) chk("push_timeout", 32'(s_ready), 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (tx_busy && n < bound) begin
      tick(1);
      n++;
    end
    chk("idle_timeout", 32'(tx_busy), 0);
  endtask

  task automatic wait_writes(input int target, input int bound);
    int n = 0;
    while (n_wr < target && n < bound) begin
      tick(1);
      n++;
    end
    chk("write_timeout", 32'(n_wr), 32'(target));
  endtask

  initial begin
    int base, pbase;
    rst = 1'b1; s_data = '0; s_valid = 1'b0; ft_txe_n = 1'b0;
    arb_en = 1'b1; gnt_block = 1'b0;
    tick(3);
    @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_wr_n", 32'(ft_wr_n), 1);
    chk("rst_dout", 32'(ft_dout), 0);
    chk("rst_oe", 32'(ft_dout_oe), 0);
    chk("rst_siwu", 32'(ft_siwu_n), 1);
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_busy", 32'(tx_busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Two-byte burst with immediate grant, then SIWU watch.
    base = n_wr; pbase = n_pulse;
    push(8'hA5);
    push(8'h3C);
    wait_idle(100);
    chk("two_byte_writes", 32'(n_wr - base), 2);
    chk("two_byte_level", 32'(fifo_level), 0);
    tick(20);
`ifdef FT245_TX_SIWU_EN
    chk("siwu_pulses", 32'(n_pulse - pbase), 1);
`else
    chk("siwu_pulses", 32'(n_pulse - pbase), 0);
`endif

    // Fill without grant, overflow attempt, then drain in MAX_BURST chunks.
    arb_en = 1'b0;
    base = n_wr;
    for (int i = 0; i < DEPTH; i++) push(8'($urandom));
    s_data = 8'hEE; s_valid = 1'b1;
    @(negedge clk);
    chk("full_s_ready", 32'(s_ready), 0);
    chk("full_level", 32'(fifo_level), DEPTH);
    @(posedge clk); #1;
    s_valid = 1'b0;
    bursts.delete();
    arb_en = 1'b1;
    wait_idle(400);
    chk("fill_writes", 32'(n_wr - base), DEPTH);
    chk("fill_bursts", 32'(bursts.size()), DEPTH / MAXB);

    // Ten bytes split into 4, 4, 2 across separate grants.
    arb_en = 1'b0;
    for (int i = 0; i < 10; i++) push(8'($urandom));
    bursts.delete();
    arb_en = 1'b1;
    wait_idle(400);
    chk("split_count", 32'(bursts.size()), 3);
    if (bursts.size() == 3) begin
      chk("split_b0", 32'(bursts[0]), 4);
      chk("split_b1", 32'(bursts[1]), 4);
      chk("split_b2", 32'(bursts[2]), 2);
    end

    // TXE# stall mid-burst keeps the bus and loses nothing.
    arb_en = 1'b0;
    for (int i = 0; i < 6; i++) push(8'($urandom));
    base = n_wr;
    arb_en = 1'b1;
    wait_writes(base + 2, 100);
    ft_txe_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("stall_bus_req", 32'(bus_req), 1);
    end
    chk("stall_writes", 32'(n_wr - base), 2);
    ft_txe_n = 1'b0;
    wait_idle(200);
    chk("stall_total", 32'(n_wr - base), 6);

    // Grant withdrawn after two writes; third byte goes first on re-grant.
    arb_en = 1'b0;
    for (int i = 0; i < 5; i++) push(8'($urandom));
    base = n_wr;
    arb_en = 1'b1;
    wait_writes(base + 2, 100);
    gnt_block = 1'b1;
    @(negedge clk);
    chk("drop_wr_n", 32'(ft_wr_n), 1);
    tick(4);
    chk("drop_writes", 32'(n_wr - base), 2);
    gnt_block = 1'b0;
    wait_idle(200);
    chk("drop_total", 32'(n_wr - base), 5);

    // Reset in the middle of a burst.
    arb_en = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    base = n_wr;
    arb_en = 1'b1;
    wait_writes(base + 2, 100);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_bus_req", 32'(bus_req), 0);
    chk("mrst_wr_n", 32'(ft_wr_n), 1);
    chk("mrst_dout", 32'(ft_dout), 0);
    chk("mrst_oe", 32'(ft_dout_oe), 0);
    chk("mrst_siwu", 32'(ft_siwu_n), 1);
    chk("mrst_level", 32'(fifo_level), 0);
    chk("mrst_busy", 32'(tx_busy), 0);
    chk("mrst_s_ready", 32'(s_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(3);

    // Randomized traffic with random TXE# and grant availability.
    for (int c = 0; c < 600; c++) begin
      s_valid  = ($urandom_range(0, 2) == 0);
      s_data   = 8'($urandom);
      ft_txe_n = ($urandom_range(0, 4) == 0);
      arb_en   = ($urandom_range(0, 7) != 0);
      tick(1);
    end
    s_valid = 1'b0; ft_txe_n = 1'b0; arb_en = 1'b1;
    wait_idle(500);
    chk("final_level", 32'(fifo_level), 0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
